hid_pad_decoder: RTL



---
 rtl/hid_pad_decoder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/hid_pad_decoder.sv
// HID gamepad report decoder: buffers a USB report, validates it and holds decoded NES buttons.
// Optional auto-fire on A/B from held X/Y is enabled by defining TURBO_EN.
module hid_pad_decoder #(
  parameter int          REPORT_BYTES = 8,
  parameter int          MIN_BYTES    = 7,
  parameter int          X_IDX        = 3,
  parameter int          Y_IDX        = 4,
  parameter int          BTN_IDX      = 5,
  parameter int          SYS_IDX      = 6,
  parameter int          DPAD_MODE    = 0,
  parameter logic [7:0]  LO_THR       = 8'h40,
  parameter logic [7:0]  HI_THR       = 8'hC0,
  parameter int          SKIP_TAG     = 1,
  parameter int          TIMEOUT_CYC  = 6000000,
  parameter int          TURBO_DIV    = 200000
) (
  input  logic                      usbclk,
  input  logic                      usbrst_n,
  input  logic                      rpt_rdy,
  input  logic                      rpt_stb,
  input  logic [7:0]                rpt_dat,
  output logic [7:0]                btn_nes,
  output logic                      btn_x,
  output logic                      btn_y,
  output logic                      rpt_valid,
  output logic [4:0]                rpt_len,
  output logic [8*REPORT_BYTES-1:0] dbg_report,
  output logic                      stale
);

  localparam logic [4:0] RB_L  = 5'(REPORT_BYTES);
  localparam logic [4:0] MIN_L = 5'(MIN_BYTES);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DECODE, COMMIT} state_e;

  state_e state_q, state_d;
  logic       stb_q, rdy_q;
  logic [4:0] cnt_q;
  logic [7:0] buf_q [REPORT_BYTES];
  logic [7:0] stg_btn_q;
  logic       stg_x_q, stg_y_q, stg_acc_q;
  logic [7:0] btn_q;
  logic       x_q, y_q, valid_q, stale_q;
  logic [4:0] len_q;
  logic [8*REPORT_BYTES-1:0] dbg_q;
  logic [TW-1:0] tmo_q;

  logic       stb_rise, rdy_fall, cap_start, cap_wr;
  logic [7:0] dec_btn;
  logic       dec_acc;
  logic [3:0] dir;

  // Hat nibble to {R,L,D,U}; codes 8..15 mean centred.
  function automatic logic [3:0] hat_dir(input logic [3:0] h);
    case (h)
      4'd0:    hat_dir = 4'b0001;
      4'd1:    hat_dir = 4'b1001;
      4'd2:    hat_dir = 4'b1000;
      4'd3:    hat_dir = 4'b1010;
      4'd4:    hat_dir = 4'b0010;
      4'd5:    hat_dir = 4'b0110;
      4'd6:    hat_dir = 4'b0100;
      4'd7:    hat_dir = 4'b0101;
      default: hat_dir = 4'b0000;
    endcase
  endfunction

  assign stb_rise  = rpt_stb & ~stb_q;
  assign rdy_fall  = rdy_q & ~rpt_rdy;
  assign cap_start = (state_d == CAPTURE) && (state_q != CAPTURE);
  assign cap_wr    = (state_q == CAPTURE) && rpt_rdy && stb_rise && (cnt_q != RB_L);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rpt_rdy) state_d = CAPTURE;
      CAPTURE: if (rdy_fall || !rpt_rdy) state_d = DECODE;
      DECODE:  state_d = COMMIT;
      COMMIT:  state_d = rpt_rdy ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dir = 4'b0000;
    if (DPAD_MODE == 0) begin
      dir[2] = buf_q[X_IDX] < LO_THR;
      dir[3] = !dir[2] && (buf_q[X_IDX] >= HI_THR);
      dir[0] = buf_q[Y_IDX] < LO_THR;
      dir[1] = !dir[0] && (buf_q[Y_IDX] >= HI_THR);
    end else begin
      dir = hat_dir(buf_q[BTN_IDX][3:0]);
    end
    dec_btn = {dir, buf_q[SYS_IDX][5], buf_q[SYS_IDX][4], buf_q[BTN_IDX][6], buf_q[BTN_IDX][5]};
    dec_acc = (cnt_q >= MIN_L) && !((SKIP_TAG != 0) && (buf_q[0][1:0] == 2'b10));
  end

  // Capture buffer and decode staging carry no reset; they are rewritten before use.
  always_ff @(posedge usbclk) begin
    for (int i = 0; i < REPORT_BYTES; i++) begin
      if (cap_start) buf_q[i] <= 8'h00;
      else if (cap_wr && (cnt_q == 5'(i))) buf_q[i] <= rpt_dat;
    end
    if (state_q == DECODE) begin
      stg_btn_q <= dec_btn;
      stg_x_q   <= buf_q[BTN_IDX][4];
      stg_y_q   <= buf_q[BTN_IDX][7];
      stg_acc_q <= dec_acc;
    end
  end

  always_ff @(posedge usbclk) begin
    if (!usbrst_n) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      btn_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      len_q   <= '0;
      dbg_q   <= '0;
      stale_q <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= rpt_stb;
      rdy_q   <= rpt_rdy;
      valid_q <= 1'b0;
      if (cap_start) cnt_q <= '0;
      else if (cap_wr) cnt_q <= cnt_q + 5'd1;
      if (state_q == DECODE) len_q <= cnt_q;
      // An accepted commit wins over a coincident timeout expiry.
      if ((state_q == COMMIT) && stg_acc_q) begin
        btn_q   <= stg_btn_q;
        x_q     <= stg_x_q;
        y_q     <= stg_y_q;
        valid_q <= 1'b1;
        stale_q <= 1'b0;
        tmo_q   <= '0;
        for (int i = 0; i < REPORT_BYTES; i++) dbg_q[8*i +: 8] <= buf_q[i];
      end else if (tmo_q == TMO_LAST) begin
        btn_q   <= '0;
        x_q     <= 1'b0;
        y_q     <= 1'b0;
        stale_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

`ifdef TURBO_EN
  localparam int TDW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [TDW-1:0] TDIV_LAST = TDW'(TURBO_DIV - 1);
  logic [TDW-1:0] tdiv_q;
  logic           phase_q;

  always_ff @(posedge usbclk) begin
    if (!usbrst_n) begin
      tdiv_q  <= '0;
      phase_q <= 1'b0;
    end else if (tdiv_q == TDIV_LAST) begin
      tdiv_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      tdiv_q <= tdiv_q + TDW'(1);
    end
  end

  assign btn_nes = {btn_q[7:2], btn_q[1] | (y_q & phase_q), btn_q[0] | (x_q & phase_q)};
`else
  assign btn_nes = btn_q;
`endif

  assign btn_x      = x_q;
  assign btn_y      = y_q;
  assign rpt_valid  = valid_q;
  assign rpt_len    = len_q;
  assign dbg_report = dbg_q;
  assign stale      = stale_q;

endmodule
